// File: rtl/servo_gen.sv
// Servo pulse generator. A word shifted in over a scan chain sets the pulse width.
// The new width takes effect at the next frame start; frames repeat every PERIOD cycles.
module servo_gen #(
  parameter int PERIOD = 20000,
  parameter int WIDTH  = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic scan_en,
  input  logic scan_in,
  output logic scan_out,
  output logic out
);

  localparam int CW = (WIDTH > 16) ? WIDTH : 16;
  localparam logic [CW-1:0] MAX_W    = CW'(PERIOD - 1);
  localparam logic [15:0]   FCNT_TOP = 16'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [WIDTH-1:0] pend_reg, pend_next;
  logic             pend_vld_reg, pend_vld_next;
  logic [WIDTH-1:0] act_reg, act_next;
  logic [15:0]      fcnt_reg, fcnt_next;
  logic [CW-1:0]    hcnt_reg, hcnt_next;
  logic             scan_en_prev_reg;
  logic             out_reg;

  logic          frame_start;
  logic          commit;
  logic [CW-1:0] act_ext;
  logic [CW-1:0] eff;

  assign scan_out = sr_reg[WIDTH-1];
  assign out      = out_reg;

  assign frame_start = (fcnt_reg == 16'd0);
  assign commit      = !scan_en && scan_en_prev_reg;

  always_comb begin
    sr_next       = sr_reg;
    pend_next     = pend_reg;
    pend_vld_next = pend_vld_reg;
    act_next      = act_reg;
    fcnt_next     = (fcnt_reg == FCNT_TOP) ? 16'd0 : fcnt_reg + 16'd1;

    if (scan_en) begin
      sr_next = {sr_reg[WIDTH-2:0], scan_in};
    end

    // The pending word moves to act first; a commit on the same edge refills
    // pend and is held back until the following frame start.
    if (frame_start && pend_vld_reg) begin
      act_next      = pend_reg;
      pend_vld_next = 1'b0;
    end
    if (commit) begin
      pend_next     = sr_reg;
      pend_vld_next = 1'b1;
    end
  end

  // Width seen by the pulse logic: the value act holds after this edge, clamped
  // so every frame has at least one low cycle.
  assign act_ext = CW'(act_next);
  assign eff     = (act_ext > MAX_W) ? MAX_W : act_ext;

  always_comb begin
    state_next = state_reg;
    hcnt_next  = hcnt_reg;
    case (state_reg)
      IDLE: begin
        if (frame_start && pend_vld_reg) begin
          state_next = (eff != '0) ? HIGH : LOW;
          hcnt_next  = CW'(1);
        end
      end
      HIGH, LOW: begin
        if (frame_start) begin
          state_next = (eff != '0) ? HIGH : LOW;
          hcnt_next  = CW'(1);
        end else if (state_reg == HIGH) begin
          if (hcnt_reg >= eff) begin
            state_next = LOW;
          end else begin
            hcnt_next = hcnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        hcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      sr_reg           <= '0;
      pend_reg         <= '0;
      pend_vld_reg     <= 1'b0;
      act_reg          <= '0;
      fcnt_reg         <= 16'd0;
      hcnt_reg         <= '0;
      scan_en_prev_reg <= 1'b0;
      out_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sr_reg           <= sr_next;
      pend_reg         <= pend_next;
      pend_vld_reg     <= pend_vld_next;
      act_reg          <= act_next;
      fcnt_reg         <= fcnt_next;
      hcnt_reg         <= hcnt_next;
      scan_en_prev_reg <= scan_en;
      out_reg          <= (state_next == HIGH);
    end
  end

endmodule

// File: tb/tb_servo_gen.sv
// Bench for servo_gen: randomized scan loads compared cycle by cycle against a
// frame-position model, plus explicit per-frame pulse counts and a two-stage chain.
module tb_servo_gen;

  localparam int P = 100;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_en = 1'b0;
  logic scan_in = 1'b0;
  logic scan_link;
  logic out;
  logic scan_out1;
  logic out1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  servo_gen #(.PERIOD(P), .WIDTH(W)) u0 (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(scan_link), .out(out)
  );

  servo_gen #(.PERIOD(P), .WIDTH(W)) u1 (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_link),
    .scan_out(scan_out1), .out(out1)
  );

  // Reference model: frame position of the next edge, a latest-word-wins
  // pending slot, and out = (position within frame < clamped width).
  logic [W-1:0] m_sr;
  logic [W-1:0] m_pend;
  bit           m_pv;
  int           m_act;
  int           m_pos;
  bit           m_prev;
  bit           exp_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sr = '0; m_pend = '0; m_pv = 0; m_act = 0; m_pos = 0; m_prev = 0; exp_out = 0;
    end else begin
      int eff;
      if (m_pos == 0 && m_pv) begin
        m_act = int'(m_pend);
        m_pv  = 0;
      end
      if (!scan_en && m_prev) begin
        m_pend = m_sr;
        m_pv   = 1;
      end
      if (scan_en) m_sr = {m_sr[W-2:0], scan_in};
      eff     = (m_act > P - 1) ? P - 1 : m_act;
      exp_out = (m_pos < eff);
      m_pos   = (m_pos + 1) % P;
      m_prev  = scan_en;
    end
  end

  task automatic shift_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      scan_en = 1'b1;
      scan_in = w[i];
      @(negedge clk);
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  // Returns at the negedge right after a frame-start edge.
  task automatic wait_frame_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      if (m_pos == 1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 1'b0 || scan_link !== 1'b0) begin
      errors++;
      $display("FAIL reset_state out=%b scan_out=%b required 0 0", out, scan_link);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 1'b0) begin
        errors++;
        $display("FAIL idle_out cycle=%0d got=%b required 0", i, out);
      end
    end
  endtask

  task automatic test_basic;
    bit ok;
    int highs;
    shift_word(12'd30);
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL basic_out cycle=%0d got=%b required %b", i, out, exp_out);
      end
    end
    wait_frame_start(ok);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      if (out === 1'b1) highs++;
      if (i < P - 1) @(negedge clk);
    end
    checks++;
    if (!ok || highs != 30) begin
      errors++;
      $display("FAIL basic_highs got=%0d required 30 (sync=%0d)", highs, ok);
    end
  endtask

  task automatic test_max_width;
    bit ok;
    int highs;
    shift_word(12'd4095);
    repeat (P) @(negedge clk);
    wait_frame_start(ok);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL max_out cycle=%0d got=%b required %b", i, out, exp_out);
      end
      if (out === 1'b1) highs++;
      if (i < P - 1) @(negedge clk);
    end
    checks++;
    if (!ok || highs != P - 1) begin
      errors++;
      $display("FAIL max_highs got=%0d required %0d", highs, P - 1);
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 10; t++) begin
      logic [W-1:0] w;
      case (t)
        0: w = 12'd0;
        1: w = 12'd1;
        2: w = 12'd99;
        3: w = 12'd100;
        default: w = W'($urandom_range(0, 4095));
      endcase
      if (t > 3 && $urandom_range(0, 1) == 1) w = W'($urandom_range(0, 120));
      repeat ($urandom_range(0, 150)) @(negedge clk);
      shift_word(w);
      for (int i = 0; i < 2 * P + 20; i++) begin
        @(negedge clk);
        checks++;
        if (out !== exp_out) begin
          errors++;
          $display("FAIL random_out word=%0d cycle=%0d got=%b required %b", w, i, out, exp_out);
        end
      end
    end
  endtask

  task automatic test_same_edge;
    bit ok;
    int highs_a;
    int highs_b;
    shift_word(12'd30);
    repeat (2 * P) @(negedge clk);
    ok = 0;
    for (int i = 0; i < 2 * P; i++) begin
      if (m_pos == P - W) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    shift_word(12'd60);
    highs_a = 0;
    highs_b = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL same_edge_out cycle=%0d got=%b required %b", i, out, exp_out);
      end
      if (out === 1'b1) begin
        if (i < P) highs_a++;
        else highs_b++;
      end
    end
    checks++;
    if (!ok || highs_a != 30 || highs_b != 60) begin
      errors++;
      $display("FAIL same_edge_highs got=%0d,%0d required 30,60", highs_a, highs_b);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int highs;
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = W'($urandom_range(1, 98));
    b = W'($urandom_range(1, 98));
    if (b == a) b = a + 12'd1;
    wait_frame_start(ok);
    repeat (5) @(negedge clk);
    shift_word(a);
    @(negedge clk);
    shift_word(b);
    wait_frame_start(ok);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL b2b_out cycle=%0d got=%b required %b", i, out, exp_out);
      end
      if (out === 1'b1) highs++;
      if (i < P - 1) @(negedge clk);
    end
    checks++;
    if (!ok || highs != int'(b)) begin
      errors++;
      $display("FAIL b2b_highs got=%0d required %0d (first word %0d)", highs, b, a);
    end
  endtask

  task automatic test_chain;
    bit ok;
    int highs0;
    int highs1;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] both;
    bit hist[$];
    a = W'($urandom_range(1, 98));
    b = W'($urandom_range(1, 98));
    both = {a, b};
    for (int i = 2 * W - 1; i >= 0; i--) begin
      scan_en = 1'b1;
      scan_in = both[i];
      hist.push_back(both[i]);
      @(negedge clk);
      if (hist.size() >= W) begin
        checks++;
        if (scan_link !== hist[hist.size() - W]) begin
          errors++;
          $display("FAIL chain_scan_out shift=%0d got=%b required %b", hist.size(), scan_link, hist[hist.size() - W]);
        end
      end
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
    wait_frame_start(ok);
    highs0 = 0;
    highs1 = 0;
    for (int i = 0; i < P; i++) begin
      if (out === 1'b1) highs0++;
      if (out1 === 1'b1) highs1++;
      if (i < P - 1) @(negedge clk);
    end
    checks++;
    if (!ok || highs1 != int'(a)) begin
      errors++;
      $display("FAIL chain_downstream_highs got=%0d required %0d", highs1, a);
    end
    checks++;
    if (highs0 != int'(b)) begin
      errors++;
      $display("FAIL chain_upstream_highs got=%0d required %0d", highs0, b);
    end
  endtask

  task automatic test_reset_mid_pulse;
    bit seen;
    shift_word(12'd50);
    seen = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (out === 1'b1) begin
        seen = 1;
        break;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (!seen || out !== 1'b0 || out1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pulse out=%b out1=%b required 0 0 (pulse seen=%0d)", out, out1, seen);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 1'b0 || scan_link !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle cycle=%0d out=%b scan_out=%b required 0 0", i, out, scan_link);
      end
    end
  endtask

  task automatic test_scan_held_through_reset;
    int highs;
    bit ok;
    rst = 1'b1;
    scan_en = 1'b1;
    scan_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * P) @(negedge clk);
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL held_scan_no_commit got=%b required 0", out);
    end
    scan_in = 1'b0;
    shift_word(12'd20);
    wait_frame_start(ok);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL held_scan_out cycle=%0d got=%b required %b", i, out, exp_out);
      end
      if (out === 1'b1) highs++;
      if (i < P - 1) @(negedge clk);
    end
    checks++;
    if (!ok || highs != 20) begin
      errors++;
      $display("FAIL held_scan_highs got=%0d required 20", highs);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_max_width();
    test_random();
    test_same_edge();
    test_back_to_back();
    test_chain();
    test_reset_mid_pulse();
    test_scan_held_through_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
